// File: rtl/shreg_pkg.sv
// Shared encodings for the shift-register sequencer: command opcodes,
// controller states and datapath modes.
package shreg_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [2:0] {HOLD, LOAD, SHL, SHR, ROL, ROR, CLR} mode_t;

    // Only the four stepping opcodes map to a moving mode; all others hold.
    function automatic mode_t step_mode(input logic [2:0] op);
        case (op)
            OP_SHL:  return SHL;
            OP_SHR:  return SHR;
            OP_ROL:  return ROL;
            OP_ROR:  return ROR;
            default: return HOLD;
        endcase
    endfunction

endpackage

// File: rtl/shreg_dp.sv
// WIDTH-bit universal parallel/shift register; performs one operation per
// clock as selected by mode and keeps the last bit moved out in sout.
module shreg_dp
    import shreg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] data,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             sout
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out  <= '0;
            sout <= 1'b0;
        end else begin
            case (mode)
                LOAD: out <= data;
                CLR: begin
                    out  <= '0;
                    sout <= 1'b0;
                end
                SHL: begin
                    out  <= {out[WIDTH-2:0], sin};
                    sout <= out[WIDTH-1];
                end
                SHR: begin
                    out  <= {sin, out[WIDTH-1:1]};
                    sout <= out[0];
                end
                ROL: begin
                    out  <= {out[WIDTH-2:0], out[WIDTH-1]};
                    sout <= out[WIDTH-1];
                end
                ROR: begin
                    out  <= {out[0], out[WIDTH-1:1]};
                    sout <= out[0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/shreg_ctrl.sv
// Command sequencer: accepts one command in IDLE, steps the datapath one
// position per clock in RUN, and pulses done for one cycle in DONE.
module shreg_ctrl
    import shreg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] amt_eff;
    logic [2:0]       op_q;
    logic             ill_q;
    logic             accept;
    logic             multi;
    mode_t            mode;

    assign accept  = (state == IDLE) && cmd_valid;
    assign amt_eff = (cmd_amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_amt;
    assign multi   = (step_mode(cmd_op) != HOLD) && (amt_eff != '0);

    // The first step happens on the accept edge itself, so mode comes from
    // the live command then and from the latched opcode during RUN.
    always_comb begin
        mode = HOLD;
        if (accept) begin
            case (cmd_op)
                OP_LOAD: mode = LOAD;
                OP_CLR:  mode = CLR;
                default: mode = multi ? step_mode(cmd_op) : HOLD;
            endcase
        end else if (state == RUN) begin
            mode = step_mode(op_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= OP_NOP;
            ill_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        ill_q <= (cmd_op == OP_ILL);
                        if (multi) begin
                            cnt   <= amt_eff - CNT_W'(1);
                            state <= (amt_eff == CNT_W'(1)) ? DONE : RUN;
                        end else begin
                            cnt   <= '0;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN) || (state == DONE);
    assign done      = (state == DONE);
    assign err       = (state == DONE) && ill_q;

    shreg_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk (clk),
        .rst (rst),
        .mode(mode),
        .data(cmd_data),
        .sin (sin),
        .out (out),
        .sout(sout)
    );

endmodule
